conf_bus_arbiter: RTL
=====================

Name: conf_bus_arbiter

Overview:
- Shares the 16-bit configuration write bus (Conf_Write / Conf_Data / Conf_Address / Conf_Free) between NREQ requesters, for example the command decoder and the shift-register loaders.
- Grants one owner at a time using round-robin and forwards the owner's write strobes onto the bus, registered.
- Revokes ownership from a stalled owner after a timeout.
- All control state is triple-redundant with majority voting, for SEU tolerance in the FE emulator.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 255, idle cycles with no owner write before the grant is revoked (1..255).
- TO_W, 8, timeout counter width.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Reset  in  1  asynchronous, active-high reset.
- Req  in  NREQ  per-requester bus request; held high for the whole ownership.
- Req_Write  in  NREQ  per-requester write strobe; one word per cycle when granted.
- Req_Data  in  16*NREQ  write data; requester i uses bits [16i+15:16i].
- Req_Address  in  16*NREQ  write address; same slicing as Req_Data.
- Err_Clear  in  1  clears Timeout_Err.
- Gnt  out  NREQ  one-hot grant, registered.
- Conf_Write_Out  out  1  bus write strobe, registered.
- Conf_Data_Out  out  16  bus data, registered.
- Conf_Address_Out  out  16  bus address, registered.
- Conf_Free_Out  out  1  high when the bus is unowned.
- Timeout_Err  out  1  sticky flag: a grant was revoked by timeout.
- Vote_Err  out  1  one-cycle pulse when any redundant copy disagrees with its vote.

Behaviour:
- Reset values (asynchronous): Gnt=0, Conf_Write_Out=0, Conf_Data_Out=0, Conf_Address_Out=0, Conf_Free_Out=1, Timeout_Err=0, Vote_Err=0, state=IDLE, owner=0, last_winner=NREQ-1 (so requester 0 wins first), timeout count=0.
- Reset asserted mid-transfer: outputs take reset values at once. Any in-flight word is dropped without a partial strobe.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If any Req bit is high at an edge, the winner is the first set bit searching upward, cyclically, from last_winner+1.
  - At that same edge: Gnt[winner]=1, owner=winner, last_winner=winner, count=0, Conf_Free_Out=0, state -> GRANT.
  - Req-to-Gnt latency is 1 cycle.
- GRANT, each edge:
  - If Req[owner]=0: Gnt=0, Conf_Write_Out=0, state -> GAP. A Req_Write arriving in the same cycle is ignored.
  - Else if Req_Write[owner]=1: Conf_Write_Out=1; Conf_Data_Out and Conf_Address_Out take the owner's slice; count=0. Word latency is 1 cycle, and back-to-back words every cycle are allowed.
  - Else: Conf_Write_Out=0 and count increments. When count reaches TIMEOUT: Gnt=0, Timeout_Err=1, state -> GAP.
- GAP: exactly one cycle with Conf_Free_Out=0 and Gnt=0, then state -> IDLE and Conf_Free_Out=1. A new grant can be issued at the earliest on the edge that leaves GAP... no: it is issued on the first edge in IDLE, so a given bus owner change costs at least 2 dead cycles.
- A revoked owner that still holds Req is treated as a fresh request. It has the lowest priority because it was last_winner.
- Conf_Data_Out and Conf_Address_Out hold their last value when no write is in progress.
- Req_Write from non-owners is ignored and never reaches the bus.
- Timeout_Err: set wins over Err_Clear when both happen in the same cycle.
- Redundancy:
  - state, owner, last_winner, count, Gnt and Timeout_Err are each held in 3 copies.
  - Every copy is loaded from the next-state logic computed on the voted values.
  - Vote_Err is registered high for one cycle whenever, at an edge, any bit of any triplet is not unanimous.
- An illegal voted state encoding recovers to GAP with Gnt=0.

Decomposition:
- Package conf_arb_pkg:
  - state encoding constants (IDLE, GRANT, GAP, 2 bits);
  - CONF_W=16;
  - function maj3 (bitwise majority of three vectors).
- Sub-module tmr_vote (parameter W): three W-bit inputs, the voted W-bit output and a mismatch flag. One instance per triplicated register group.
- Round-robin search is a function in the package.

Test Plan:
- Reset, then Req=0001 with 3 back-to-back Req_Write (addr 0x0010..0x0012, data 0xA5A5..0xA5A7) -> Gnt=0001 one cycle after Req; 3 consecutive Conf_Write_Out pulses carrying those values, each 1 cycle after its input; Conf_Free_Out=0 throughout.
- Req=1111 held, each owner writes one word then drops Req for one cycle -> grant order 0,1,2,3,0; 2 dead cycles (GAP then IDLE) between owners; Conf_Free_Out=1 only in the IDLE cycle.
- Owner 2 granted, TIMEOUT=255, no writes -> Gnt drops after exactly 255 idle cycles; Timeout_Err=1 and stays set until Err_Clear; the next grant goes to requester 3 if it is requesting.
- Owner drops Req in the same cycle as Req_Write=1 -> no Conf_Write_Out pulse; Conf_Data_Out unchanged.
- Force one copy of the state register to a wrong value mid-GRANT -> Vote_Err pulses once; bus traffic is unaffected; the copy is rewritten on the next edge.
- Reset asserted during a write burst -> all outputs at reset values immediately; after release, Req=0010 is granted with requester 0 priority restored (last_winner=NREQ-1).

Source files
------------

// File: rtl/conf_arb_pkg.sv
// Shared types and helpers for the configuration bus arbiter: state encoding,
// bus width, majority vote and the round-robin winner search.
package conf_arb_pkg;

  localparam int CONF_W  = 16;
  localparam int MAX_REQ = 8;
  localparam int OWN_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  function automatic logic [31:0] maj3(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // First set request searching upward, cyclically, from last+1; last itself
  // is checked last so the previous winner has the lowest priority.
  function automatic logic [OWN_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                               input logic [OWN_W-1:0]   last,
                                               input int                 nreq);
    logic [OWN_W-1:0] win;
    int idx;
    win = last;
    for (int i = MAX_REQ; i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= nreq) idx = idx - nreq;
      if (i <= nreq && req[idx[OWN_W-1:0]]) win = idx[OWN_W-1:0];
    end
    return win;
  endfunction

endpackage

// File: rtl/conf_bus_arbiter_tmr_vote.sv
// Majority voter for one triplicated register group, with a disagreement flag.
module tmr_vote
  import conf_arb_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] v_o,
  output logic         err_o
);

  assign v_o   = W'(maj3(32'(a_i), 32'(b_i), 32'(c_i)));
  assign err_o = (a_i != v_o) || (b_i != v_o) || (c_i != v_o);

endmodule

// File: rtl/conf_bus_arbiter.sv
// Round-robin owner arbitration of the configuration write bus with stall
// timeout; all control state is held in three voted copies.
module conf_bus_arbiter
  import conf_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NREQ-1:0]        Req,
  input  logic [NREQ-1:0]        Req_Write,
  input  logic [CONF_W*NREQ-1:0] Req_Data,
  input  logic [CONF_W*NREQ-1:0] Req_Address,
  input  logic                   Err_Clear,
  output logic [NREQ-1:0]        Gnt,
  output logic                   Conf_Write_Out,
  output logic [CONF_W-1:0]      Conf_Data_Out,
  output logic [CONF_W-1:0]      Conf_Address_Out,
  output logic                   Conf_Free_Out,
  output logic                   Timeout_Err,
  output logic                   Vote_Err
);

  logic [2:0][1:0]       st_q;
  logic [2:0][OWN_W-1:0] own_q, lw_q;
  logic [2:0][TO_W-1:0]  cnt_q;
  logic [2:0][NREQ-1:0]  gnt_q;
  logic [2:0]            terr_q;

  arb_state_e            st_d;
  logic [OWN_W-1:0]      own_d, lw_d;
  logic [TO_W-1:0]       cnt_d;
  logic [NREQ-1:0]       gnt_d;
  logic                  terr_d;

  logic [1:0]            st_v;
  logic [OWN_W-1:0]      own_v, lw_v;
  logic [TO_W-1:0]       cnt_v;
  logic [NREQ-1:0]       gnt_v;
  logic                  terr_v;
  logic [5:0]            mm;

  logic                  cw_q, cw_d;
  logic [CONF_W-1:0]     cd_q, cd_d, ca_q, ca_d;
  logic                  verr_q;

  logic [MAX_REQ-1:0]    req_pad, wr_pad;
  logic [OWN_W-1:0]      winner;
  logic [CONF_W-1:0]     own_data, own_addr;
  logic [TO_W-1:0]       cnt_inc;
  logic                  terr_set;

  tmr_vote #(.W(2))     u_vote_st   (.a_i(st_q[0]),   .b_i(st_q[1]),   .c_i(st_q[2]),   .v_o(st_v),   .err_o(mm[0]));
  tmr_vote #(.W(OWN_W)) u_vote_own  (.a_i(own_q[0]),  .b_i(own_q[1]),  .c_i(own_q[2]),  .v_o(own_v),  .err_o(mm[1]));
  tmr_vote #(.W(OWN_W)) u_vote_lw   (.a_i(lw_q[0]),   .b_i(lw_q[1]),   .c_i(lw_q[2]),   .v_o(lw_v),   .err_o(mm[2]));
  tmr_vote #(.W(TO_W))  u_vote_cnt  (.a_i(cnt_q[0]),  .b_i(cnt_q[1]),  .c_i(cnt_q[2]),  .v_o(cnt_v),  .err_o(mm[3]));
  tmr_vote #(.W(NREQ))  u_vote_gnt  (.a_i(gnt_q[0]),  .b_i(gnt_q[1]),  .c_i(gnt_q[2]),  .v_o(gnt_v),  .err_o(mm[4]));
  tmr_vote #(.W(1))     u_vote_terr (.a_i(terr_q[0]), .b_i(terr_q[1]), .c_i(terr_q[2]), .v_o(terr_v), .err_o(mm[5]));

  assign req_pad = MAX_REQ'(Req);
  assign wr_pad  = MAX_REQ'(Req_Write);
  assign winner  = rr_pick(req_pad, lw_v, NREQ);
  assign cnt_inc = cnt_v + TO_W'(1);

  always_comb begin
    own_data = '0;
    own_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (own_v == OWN_W'(i)) begin
        own_data = Req_Data[i*CONF_W +: CONF_W];
        own_addr = Req_Address[i*CONF_W +: CONF_W];
      end
    end
  end

  always_comb begin
    st_d     = arb_state_e'(st_v);
    own_d    = own_v;
    lw_d     = lw_v;
    cnt_d    = cnt_v;
    gnt_d    = gnt_v;
    terr_set = 1'b0;
    cw_d     = 1'b0;
    cd_d     = cd_q;
    ca_d     = ca_q;
    case (arb_state_e'(st_v))
      IDLE: begin
        gnt_d = '0;
        if (|Req) begin
          st_d  = GRANT;
          own_d = winner;
          lw_d  = winner;
          cnt_d = '0;
          gnt_d = NREQ'(1) << winner;
        end
      end
      GRANT: begin
        if (!req_pad[own_v]) begin
          gnt_d = '0;
          st_d  = GAP;
        end else if (wr_pad[own_v]) begin
          cw_d  = 1'b1;
          cd_d  = own_data;
          ca_d  = own_addr;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_W'(TIMEOUT)) begin
            gnt_d    = '0;
            st_d     = GAP;
            terr_set = 1'b1;
          end
        end
      end
      GAP: begin
        gnt_d = '0;
        st_d  = IDLE;
      end
      default: begin
        gnt_d = '0;
        st_d  = GAP;
      end
    endcase
    // a fresh timeout outranks a simultaneous clear
    terr_d = terr_set | (terr_v & ~Err_Clear);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      st_q   <= {3{IDLE}};
      own_q  <= '0;
      lw_q   <= {3{OWN_W'(NREQ-1)}};
      cnt_q  <= '0;
      gnt_q  <= '0;
      terr_q <= '0;
      cw_q   <= 1'b0;
      cd_q   <= '0;
      ca_q   <= '0;
      verr_q <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        st_q[k]   <= st_d;
        own_q[k]  <= own_d;
        lw_q[k]   <= lw_d;
        cnt_q[k]  <= cnt_d;
        gnt_q[k]  <= gnt_d;
        terr_q[k] <= terr_d;
      end
      cw_q   <= cw_d;
      cd_q   <= cd_d;
      ca_q   <= ca_d;
      verr_q <= |mm;
    end
  end

  assign Gnt              = gnt_v;
  assign Conf_Write_Out   = cw_q;
  assign Conf_Data_Out    = cd_q;
  assign Conf_Address_Out = ca_q;
  assign Conf_Free_Out    = (st_v == IDLE);
  assign Timeout_Err      = terr_v;
  assign Vote_Err         = verr_q;

endmodule
